// File: rtl/dds_am_envelope_sequencer.sv
// Walks an AM envelope table with a phase accumulator and scales each accepted carrier sample by the fetched word.
// Latency: accept to out_valid is 3 cycles, 4 cycles per sample; out_valid/out_data hold until out_ready.
module dds_am_envelope_sequencer #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                sync,
  input  logic [PHASE_W-1:0]  cfg_ftw,
  input  logic                cfg_update,
  output logic                cfg_ack,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  input  logic [DATA_W-1:0]   ram_readdata,
  input  logic                car_valid,
  output logic                car_ready,
  input  logic [DATA_W-1:0]   car_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data
);

  typedef enum logic [1:0] {IDLE, READ, SCALE, OUT} state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   ftw_active_q, ftw_active_d;
  logic [PHASE_W-1:0]   pending_q, pending_d;
  logic                 pend_flag_q, pend_flag_d;
  logic                 sync_flag_q, sync_flag_d;
  logic [DATA_W-1:0]    car_q, car_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 cs_q, cs_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 run_q;
  logic                 accept;
  logic                 apply;
  logic signed [2*DATA_W:0] product;

  // run_q keeps car_ready low while reset is held, independent of enable
  assign car_ready      = run_q & enable & (state_q == IDLE);
  assign accept         = car_valid & car_ready;
  assign apply          = (state_q == IDLE) & pend_flag_q & ~accept;
  assign cfg_ack        = apply;
  assign out_valid      = (state_q == OUT);
  assign ram_address    = addr_q;
  assign ram_chipselect = cs_q;
  assign out_data       = out_data_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    ftw_active_d = ftw_active_q;
    pending_d    = pending_q;
    pend_flag_d  = pend_flag_q;
    sync_flag_d  = sync_flag_q | sync;
    car_d        = car_q;
    addr_d       = '0;
    cs_d         = 1'b0;
    out_data_d   = out_data_q;
    product      = $signed(car_q) * $signed({1'b0, ram_readdata});

    if (apply) begin
      ftw_active_d = pending_q;
      pend_flag_d  = 1'b0;
    end
    // A write in the same cycle as an apply stays pending for the next idle slot
    if (cfg_update) begin
      pending_d   = cfg_ftw;
      pend_flag_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          car_d   = car_data;
          cs_d    = 1'b1;
          state_d = READ;
          if (sync_flag_q | sync) begin
            addr_d      = '0;
            phase_d     = ftw_active_q;
            sync_flag_d = 1'b0;
          end else begin
            addr_d  = phase_q[PHASE_W-1 -: ADDR_W];
            phase_d = phase_q + ftw_active_q;
          end
        end
      end
      READ:  state_d = SCALE;
      SCALE: begin
        out_data_d = DATA_W'(product >>> DATA_W);
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      ftw_active_q <= '0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      sync_flag_q  <= 1'b0;
      car_q        <= '0;
      addr_q       <= '0;
      cs_q         <= 1'b0;
      out_data_q   <= '0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      ftw_active_q <= ftw_active_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      sync_flag_q  <= sync_flag_d;
      car_q        <= car_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      out_data_q   <= out_data_d;
      run_q        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dds_am_envelope_sequencer.sv
// Directed and randomized sample stream against a phase/envelope reference model and a RAM model.
module tb_dds_am_envelope_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sync;
  logic [31:0] cfg_ftw;
  logic        cfg_update;
  logic        cfg_ack;
  logic [9:0]  ram_address;
  logic        ram_chipselect;
  logic [15:0] ram_readdata;
  logic        car_valid;
  logic        car_ready;
  logic [15:0] car_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  dds_am_envelope_sequencer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sync(sync),
    .cfg_ftw(cfg_ftw), .cfg_update(cfg_update), .cfg_ack(cfg_ack),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_readdata(ram_readdata),
    .car_valid(car_valid), .car_ready(car_ready), .car_data(car_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Envelope RAM: registered address, unregistered read data
  logic [15:0] tbl [0:1023];
  logic [9:0]  raddr = '0;
  always @(posedge clk) if (ram_chipselect) raddr <= ram_address;
  assign ram_readdata = tbl[raddr];

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_phase, m_ftw, m_pend_v;
  bit          m_pend, m_sync;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = '0; m_ftw = '0; m_pend_v = '0; m_pend = 0; m_sync = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_car_ready"}, car_ready, 0);
    chk({tag, "_cfg_ack"}, cfg_ack, 0);
    chk({tag, "_cs"}, ram_chipselect, 0);
    chk({tag, "_addr"}, ram_address, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  // One IDLE cycle with no carrier offered: any pending FTW must be acknowledged now
  task automatic idle_cycle();
    car_valid = 0;
    chk("cfg_ack_idle", cfg_ack, m_pend);
    if (m_pend) begin m_ftw = m_pend_v; m_pend = 0; end
    @(negedge clk);
  endtask

  task automatic set_ftw(input logic [31:0] v);
    cfg_update = 1; cfg_ftw = v; m_pend = 1; m_pend_v = v;
    @(negedge clk);
    cfg_update = 0;
    idle_cycle();
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
  // sync_mode: 0 none, 1 pulse during READ, 2 pulse with the accept.
  // upd_n: number of cfg_update pulses issued while the sample is in flight.
  task automatic do_sample(input logic [15:0] car, input int stall, input int sync_mode,
                           input int upd_n, input logic [31:0] upd_a, input logic [31:0] upd_b,
                           input bit rst_scale, input bit en_drop);
    logic [9:0]  ea;
    logic [15:0] eo;
    longint      p;
    int          w;
    car_valid = 1; car_data = car;
    if (sync_mode == 2) begin sync = 1; m_sync = 1; end
    w = 0;
    while (!car_ready && w < 20) begin
      if (m_pend) begin m_ftw = m_pend_v; m_pend = 0; end
      @(negedge clk);
      w++;
    end
    chk("car_ready_wait", car_ready, 1);
    ea      = m_sync ? 10'd0 : m_phase[31:22];
    m_phase = m_sync ? m_ftw : m_phase + m_ftw;
    m_sync  = 0;
    p  = longint'($signed(car)) * longint'(tbl[ea]);
    eo = 16'(p >>> 16);

    @(negedge clk);  // READ
    car_valid = 0; sync = 0;
    chk("read_addr", ram_address, ea);
    chk("read_cs", ram_chipselect, 1);
    chk("read_car_ready", car_ready, 0);
    chk("read_out_valid", out_valid, 0);
    if (sync_mode == 1) begin sync = 1; m_sync = 1; end
    if (en_drop) enable = 0;
    if (upd_n > 0) begin cfg_update = 1; cfg_ftw = upd_a; m_pend = 1; m_pend_v = upd_a; end

    @(negedge clk);  // SCALE
    sync = 0;
    if (upd_n == 2) begin cfg_ftw = upd_b; m_pend_v = upd_b; end
    else cfg_update = 0;
    chk("scale_cs", ram_chipselect, 0);
    chk("scale_out_valid", out_valid, 0);
    chk("scale_cfg_ack", cfg_ack, 0);
    if (rst_scale) begin
      cfg_update = 0;
      reset_n = 0;
      #1;
      chk_all_zero("rst_scale");
      model_reset();
      @(negedge clk);
      reset_n = 1;
      return;
    end
    if (stall > 0) out_ready = 0;

    @(negedge clk);  // OUT
    cfg_update = 0;
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, eo);
    chk("out_cs", ram_chipselect, 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, eo);
      chk("stall_car_ready", car_ready, 0);
      chk("stall_cs", ram_chipselect, 0);
    end
    out_ready = 1;

    @(negedge clk);  // back in IDLE
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    reset_n = 0; enable = 1; sync = 0; cfg_ftw = '0; cfg_update = 0;
    car_valid = 0; car_data = '0; out_ready = 1;
    for (int i = 0; i < 1024; i++) tbl[i] = 16'h8000;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1;
    @(negedge clk);

    // Streaming with step 1: addresses 0..4, product 0x2000
    set_ftw(32'h0040_0000);
    for (int i = 0; i < 5; i++) do_sample(16'h4000, 0, 0, 0, 0, 0, 0, 0);
    // Sync mid-stream at phase 0x01400000
    do_sample(16'h4000, 0, 1, 0, 0, 0, 0, 0);
    do_sample(16'h4000, 0, 0, 0, 0, 0, 0, 0);
    do_sample(16'h4000, 0, 0, 0, 0, 0, 0, 0);
    // Downstream stall
    do_sample(16'h4000, 10, 0, 0, 0, 0, 0, 0);
    // FTW update while in flight, then double update (last wins, one ack)
    do_sample(16'h4000, 0, 0, 1, 32'h0080_0000, 0, 0, 0);
    idle_cycle();
    do_sample(16'h4000, 0, 0, 0, 0, 0, 0, 0);
    do_sample(16'h4000, 0, 0, 0, 0, 0, 0, 0);
    do_sample(16'h4000, 0, 0, 2, 32'h00C0_0000, 32'h0010_0000, 0, 0);
    idle_cycle();
    idle_cycle();
    chk("ftw_last_wins", m_ftw, 32'h0010_0000);
    do_sample(16'h4000, 0, 0, 0, 0, 0, 0, 0);

    // Envelope extremes and sign handling
    tbl[0] = 16'hFFFF;
    set_ftw(32'h0);
    do_sample(16'h7FFF, 0, 2, 0, 0, 0, 0, 0);
    do_sample(16'h8000, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = 16'h8000;
    do_sample(16'hC000, 0, 0, 0, 0, 0, 0, 0);

    // Large and wrapping steps
    set_ftw(32'h8000_0000);
    for (int i = 0; i < 3; i++) do_sample(16'h1234, 0, (i == 0) ? 2 : 0, 0, 0, 0, 0, 0);
    set_ftw(32'hFFC0_0000);
    for (int i = 0; i < 3; i++) do_sample(16'hEDCB, 0, (i == 0) ? 2 : 0, 0, 0, 0, 0, 0);

    // enable dropped mid-sample: sample completes, no further accepts
    do_sample(16'h2222, 0, 0, 0, 0, 0, 0, 1);
    car_valid = 1;
    for (int i = 0; i < 3; i++) begin
      chk("disabled_car_ready", car_ready, 0);
      @(negedge clk);
      chk("disabled_cs", ram_chipselect, 0);
    end
    car_valid = 0;
    enable = 1;

    // Randomized stream
    for (int i = 0; i < 1024; i++) tbl[i] = 16'($urandom);
    set_ftw($urandom);
    for (int i = 0; i < 40; i++) begin
      int sm;
      sm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      if ($urandom_range(0, 9) == 0) set_ftw($urandom);
      do_sample(16'($urandom), int'($urandom_range(0, 2)), sm, 0, 0, 0, 0, 0);
    end

    // Reset during SCALE, then restart from phase 0
    do_sample(16'h5555, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    set_ftw(32'h0040_0000);
    for (int i = 0; i < 3; i++) do_sample(16'($urandom), 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
